// File: rtl/sar_search_ctrl_if.sv
// Bus between the SAR search controller and its comparator/requester side.
// Carries start, comparator flags, trial operand and completion status.
interface sar_search_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             cmp_lt;
    logic             cmp_eq;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, cmp_lt, cmp_eq,
        input  trial, busy, done, result
    );

    modport slave (
        input  start, cmp_lt, cmp_eq,
        output trial, busy, done, result
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search: converges MSB-first on the comparator's A operand.
// Optional macro SAR_EARLY_EXIT_EN: finish as soon as the comparator reports equality.
module sar_search_ctrl #(
    parameter int WIDTH   = 8,
    parameter int CMP_LAT = 0
) (
    input  logic               clk,
    input  logic               rst,
    sar_search_ctrl_if.slave   bus_if
);
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_TEST = 2'd2;

    localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(WIDTH - 1);
    localparam logic [1:0]       WAIT_LOAD  = (CMP_LAT > 0) ? 2'(CMP_LAT - 1) : 2'd0;
    localparam logic [1:0]       STEP_STATE = (CMP_LAT > 0) ? ST_WAIT : ST_TEST;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] trial_q,  trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [1:0]       cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             hit_eq;

`ifdef SAR_EARLY_EXIT_EN
    // Lower bits of the trial are still zero, so an equal trial is already exact.
    assign hit_eq = bus_if.cmp_eq & ~bus_if.cmp_lt;
`else
    assign hit_eq = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.start) begin
                    trial_d = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_d   = IDX_MSB;
                    busy_d  = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = STEP_STATE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) state_d = ST_TEST;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ST_TEST: begin
                if (bus_if.cmp_lt) trial_d[idx_q] = 1'b0;
                if (hit_eq || idx_q == '0) begin
                    result_d = trial_d;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    trial_d[idx_q - 1'b1] = 1'b1;
                    idx_d   = idx_q - 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = STEP_STATE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= IDX_MSB;
            cnt_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus_if.trial  = trial_q;
    assign bus_if.result = result_q;
    assign bus_if.busy   = busy_q;
    assign bus_if.done   = done_q;
endmodule
